// File: rtl/c2b1.sv
// Serial-to-nibble block converter: collects 4*NIB_CNT bits LSB-first,
// then emits them as NIB_CNT nibbles, most-significant nibble first.
module c2b1 #(
  parameter int NIB_CNT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       c2b_in,
  input  logic       c2b_en,
  output logic [3:0] c2b_out,
  output logic       c2b_valid,
  output logic       c2b_last,
  output logic       c2b_ovf
);

  localparam int W  = 4 * NIB_CNT;
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam int NW = (NIB_CNT > 1) ? $clog2(NIB_CNT) : 1;

  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);
  localparam logic [NW-1:0] LAST_NIB = NW'(NIB_CNT - 1);
  localparam logic          ONE_NIB  = (NIB_CNT == 1);

  typedef enum logic {
    COLLECT,
    EMIT
  } state_e;

  state_e          state_q;
  logic [W-1:0]    buf_q;
  logic [W-1:0]    buf_d;
  logic [BW-1:0]   bit_cnt_q;
  logic [NW-1:0]   nib_q;
  logic [NW-1:0]   nib_d;
  logic [3:0]      first_nib;
  logic [3:0]      next_nib;

  // The first nibble contains the bit being accepted, so it is taken
  // from the updated buffer to meet the one-cycle latency.
  always_comb begin
    buf_d            = buf_q;
    buf_d[bit_cnt_q] = c2b_in;
    first_nib        = buf_d[W-1 -: 4];
    nib_d            = nib_q + NW'(1);
    next_nib         = 4'(buf_q >> (4 * (NIB_CNT - 1 - int'(nib_d))));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      buf_q     <= '0;
      bit_cnt_q <= '0;
      nib_q     <= '0;
      c2b_out   <= '0;
      c2b_valid <= 1'b0;
      c2b_last  <= 1'b0;
      c2b_ovf   <= 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (c2b_en) begin
            buf_q <= buf_d;
            if (bit_cnt_q == LAST_BIT) begin
              state_q   <= EMIT;
              bit_cnt_q <= '0;
              nib_q     <= '0;
              c2b_valid <= 1'b1;
              c2b_out   <= first_nib;
              c2b_last  <= ONE_NIB;
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end
          end
        end
        EMIT: begin
          if (c2b_en) begin
            c2b_ovf <= 1'b1;
          end
          if (nib_q == LAST_NIB) begin
            state_q   <= COLLECT;
            buf_q     <= '0;
            nib_q     <= '0;
            c2b_valid <= 1'b0;
            c2b_out   <= '0;
            c2b_last  <= 1'b0;
          end else begin
            nib_q    <= nib_d;
            c2b_out  <= next_nib;
            c2b_last <= (nib_d == LAST_NIB);
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_c2b1.sv
// Randomized scoreboard bench for c2b1: a block-level model predicts
// each nibble with the cycle it must appear in, plus the overrun flag.
module tb_c2b1;

  localparam int N = 16;
  localparam int W = 4 * N;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       c2b_in = 1'b0;
  logic       c2b_en = 1'b0;
  logic [3:0] c2b_out;
  logic       c2b_valid;
  logic       c2b_last;
  logic       c2b_ovf;

  c2b1 #(.NIB_CNT(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .c2b_in   (c2b_in),
    .c2b_en   (c2b_en),
    .c2b_out  (c2b_out),
    .c2b_valid(c2b_valid),
    .c2b_last (c2b_last),
    .c2b_ovf  (c2b_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] nib;
    logic       last;
  } exp_t;

  exp_t         sbq[$];
  exp_t         mon_e;
  int           cyc    = 0;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_acc  = '0;
  int           m_cnt  = 0;
  int           m_busy = 0;
  logic         m_ovf  = 1'b0;

  // Reference: gather W accepted bits into a word; a full word yields
  // N nibbles on the N following cycles, during which bits are dropped.
  function automatic void model(input logic r, input logic en,
                                input logic b);
    exp_t e;
    if (r) begin
      sbq.delete();
      m_acc  = '0;
      m_cnt  = 0;
      m_busy = 0;
      m_ovf  = 1'b0;
      return;
    end
    if (m_busy > 0) begin
      m_busy--;
      if (en) m_ovf = 1'b1;
      return;
    end
    if (!en) return;
    m_acc[m_cnt] = b;
    m_cnt++;
    if (m_cnt == W) begin
      for (int i = 0; i < N; i++) begin
        e.cyc  = cyc + i;
        e.nib  = m_acc[W-1-4*i -: 4];
        e.last = (i == N - 1);
        sbq.push_back(e);
      end
      m_cnt  = 0;
      m_acc  = '0;
      m_busy = N;
    end
  endfunction

  task automatic tick(input logic r, input logic en, input logic b);
    rst    = r;
    c2b_en = en;
    c2b_in = b;
    @(posedge clk);
    cyc++;
    model(r, en, b);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'($urandom));
  endtask

  task automatic send(input logic [W-1:0] d, input bit gapped);
    int stall_at;
    stall_at = $urandom_range(1, W - 2);
    for (int i = 0; i < W; i++) begin
      tick(1'b0, 1'b1, d[i]);
      if (gapped && i < W - 1) begin
        tick(1'b0, 1'b0, 1'($urandom));
        if (i == stall_at) idle(5);
      end
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) w[i] = 1'($urandom);
    return w;
  endfunction

  always @(negedge clk) begin
    checks++;
    if (c2b_valid) begin
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL spurious_valid cyc=%0d got out=%h last=%b want no valid",
                 cyc, c2b_out, c2b_last);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.cyc != cyc || mon_e.nib !== c2b_out ||
            mon_e.last !== c2b_last) begin
          errors++;
          $display("FAIL nibble cyc=%0d got out=%h last=%b want cyc=%0d out=%h last=%b",
                   cyc, c2b_out, c2b_last, mon_e.cyc, mon_e.nib, mon_e.last);
        end
      end
    end else begin
      if (c2b_out !== 4'h0 || c2b_last !== 1'b0 ||
          (sbq.size() > 0 && sbq[0].cyc <= cyc)) begin
        errors++;
        $display("FAIL idle cyc=%0d got valid=0 out=%h last=%b want out=0 last=0 pending=%0d",
                 cyc, c2b_out, c2b_last, sbq.size());
        if (sbq.size() > 0 && sbq[0].cyc <= cyc) void'(sbq.pop_front());
      end
    end
    checks++;
    if (c2b_ovf !== m_ovf) begin
      errors++;
      $display("FAIL ovf cyc=%0d got %b want %b", cyc, c2b_ovf, m_ovf);
    end
  end

  initial begin
    repeat (3) tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0);

    send(64'h0123456789ABCDEF, 1'b0);
    idle(N + 2);
    send(64'h0123456789ABCDEF, 1'b1);
    idle(N + 2);

    send(rnd_word(), 1'b0);
    idle(2);
    repeat (3) tick(1'b0, 1'b1, 1'($urandom));
    idle(N);
    send(rnd_word(), 1'b0);
    idle(N + 2);

    for (int i = 0; i < 30; i++) tick(1'b0, 1'b1, 1'($urandom));
    tick(1'b1, 1'b0, 1'b0);
    idle(3);
    send(rnd_word(), 1'b0);
    idle(7);
    tick(1'b1, 1'b1, 1'b1);
    idle(3);
    send(64'hFEDCBA9876543210, 1'b0);
    idle(N + 2);

    send({W{1'b1}}, 1'b0);
    idle(N);
    send(64'hA5A5A5A5A5A5A5A5, 1'b0);
    idle(N + 2);

    tick(1'b1, 1'b0, 1'b0);
    repeat (6) begin
      send(rnd_word(), 1'($urandom));
      for (int k = 0; k < N + int'($urandom_range(0, 4)); k++)
        tick(1'b0, $urandom_range(0, 3) == 0, 1'($urandom));
    end
    idle(W + N + 4);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d pending nibbles want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/c2b1.md
C2B1 -- requirements
Module: c2b1

Interface
REQ-001 The module SHALL have parameter NIB_CNT, default 16, giving the number of 4-bit nibbles per block; the block length is 4*NIB_CNT bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port c2b_in, input, 1 bit: serial data bit.
REQ-005 The module SHALL have port c2b_en, input, 1 bit: c2b_in is valid in this cycle.
REQ-006 The module SHALL have port c2b_out, output, 4 bits: the parallel nibble.
REQ-007 The module SHALL have port c2b_valid, output, 1 bit: c2b_out holds a nibble in this cycle.
REQ-008 The module SHALL have port c2b_last, output, 1 bit: the final nibble of the block, coincident with c2b_valid.
REQ-009 The module SHALL have port c2b_ovf, output, 1 bit: sticky overrun flag.

Function
REQ-010 All outputs SHALL be registered.
REQ-011 The module SHALL implement two states: COLLECT (the state after reset) and EMIT.
REQ-012 In COLLECT, for each cycle with c2b_en=1, the module SHALL write c2b_in to buf[bit_cnt] and increment bit_cnt; bit 0 of the block is received first.
REQ-013 In COLLECT, a cycle with c2b_en=0 SHALL leave buf and bit_cnt unchanged; gaps of any length are legal.
REQ-014 When a bit is accepted while bit_cnt = 4*NIB_CNT-1, the module SHALL enter EMIT on the next edge and clear bit_cnt to 0.
REQ-015 In EMIT, the module SHALL assert c2b_valid for exactly NIB_CNT consecutive cycles.
REQ-016 In output cycle i (i = 0..NIB_CNT-1), c2b_out SHALL equal buf[4*NIB_CNT-1-4i : 4*NIB_CNT-4-4i]; the most-significant nibble is sent first.
REQ-017 c2b_valid SHALL first be asserted in the cycle immediately after the edge that samples the last bit (latency of 1 cycle).
REQ-018 c2b_last SHALL be 1 only in output cycle NIB_CNT-1.
REQ-019 After output cycle NIB_CNT-1, the module SHALL return to COLLECT, and the next accepted bit SHALL be stored as bit 0 of a new block.
REQ-020 The module SHALL clear buf to 0 on entering COLLECT.
REQ-021 Whenever c2b_valid=0, c2b_out and c2b_last SHALL both be 0.
REQ-022 In EMIT, any cycle with c2b_en=1 SHALL discard that bit and set c2b_ovf to 1.
REQ-023 In EMIT, an incoming bit SHALL NOT alter buf, bit_cnt or the nibble sequence.
REQ-024 c2b_ovf SHALL remain 1 until reset.
REQ-025 There SHALL be no downstream backpressure: the consumer must accept one nibble per cycle while c2b_valid=1.
REQ-026 bit_cnt SHALL be ceil(log2(4*NIB_CNT)) bits wide and SHALL never wrap past 4*NIB_CNT-1.
REQ-027 The nibble counter SHALL be ceil(log2(NIB_CNT)) bits wide; NIB_CNT=1 SHALL be supported with a 1-bit counter.

Reset
REQ-028 While rst=1 at a clock edge, the module SHALL set state to COLLECT and clear buf, bit_cnt and the nibble counter to 0.
REQ-029 While rst=1 at a clock edge, the module SHALL set c2b_out=0, c2b_valid=0, c2b_last=0 and c2b_ovf=0.
REQ-030 Reset asserted mid-COLLECT or mid-EMIT SHALL discard the partial block with no further nibbles emitted; inputs are ignored during reset cycles.
REQ-031 The first c2b_en=1 cycle after rst deasserts SHALL be accepted as bit 0.

Verification
REQ-032 Reset check: hold rst=1 for 3 cycles with c2b_en=1 -> all outputs 0 throughout and one cycle after release.
REQ-033 Nominal block: send the 64 bits of 0x0123456789ABCDEF LSB-first with c2b_en held high -> c2b_valid high for 16 cycles starting the cycle after bit 63, c2b_out = 0x0,0x1,...,0xF, c2b_last only with 0xF, c2b_ovf=0.
REQ-034 Gapped input: same data with c2b_en toggling 1/0 plus a random 5-cycle stall -> identical nibble sequence, with first valid one cycle after the last accepted bit.
REQ-035 Overrun: hold c2b_en=1 during cycles 3-5 of EMIT -> c2b_ovf=1 from the following cycle onward, the nibble sequence is unchanged, and the next block starts clean at bit 0.
REQ-036 Reset mid-operation: assert rst after 30 bits, and again during nibble 7 of a later EMIT -> no further valid nibbles; a subsequent full block of 0xFEDCBA9876543210 emits 0xF down to 0x0.
REQ-037 Back-to-back: two blocks (all-ones, then 0xA5A5A5A5A5A5A5A5) with c2b_en low only during EMIT -> 16 nibbles of 0xF, then 0xA,0x5 repeated 8 times, with two c2b_last pulses.
